pciecfg_mgmt_responder: RTL

Target-side model of the PCIe cfg_mgmt configuration-management interface. It answers dword read/write requests from the config-access engine with a shadow Type-0 config space, a fixed request-to-done latency and a single-cycle done pulse. It is used as the stand-in endpoint for board-level loopback and simulation of the pciecfg path, and it also serves as a shadow config space in builds without the hard IP.

---
 rtl/pciecfg_mgmt_responder.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/pciecfg_mgmt_responder.sv
// Target-side cfg_mgmt responder: shadow Type-0 config space with a fixed
// request-to-done latency, one-cycle done pulse and read/write completion counters.
module pciecfg_mgmt_responder #(
  parameter int unsigned ADDR_W        = 6,
  parameter int unsigned LATENCY       = 2,
  parameter logic [31:0] ID_WORD       = 32'h7024_10EE,
  parameter logic [31:0] CLASSREV_WORD = 32'h0200_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  i_cfg_mgmt_dwaddr,
  input  logic        i_cfg_mgmt_rd_en,
  input  logic        i_cfg_mgmt_wr_en,
  input  logic [3:0]  i_cfg_mgmt_byte_en,
  input  logic [31:0] i_cfg_mgmt_di,
  output logic [31:0] o_cfg_mgmt_do,
  output logic        o_cfg_mgmt_rd_wr_done,
  output logic        o_err_proto,
  output logic [15:0] o_rd_count,
  output logic [15:0] o_wr_count
);

  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned DWA_W   = 10;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CTR_W   = 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_DONE    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DWA_W-1:0]    r_addr;
  logic [3:0]          r_be;
  logic [DATA_W-1:0]   r_di;
  logic                r_op_wr;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [DATA_W-1:0]   r_do;
  logic                r_done;
  logic                r_err_proto;
  logic [CTR_W-1:0]    r_rd_count;
  logic [CTR_W-1:0]    r_wr_count;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_req;
  logic                w_accept;
  logic                w_enter_done;
  logic                w_enter_rd;
  logic [DWA_W-1:0]    w_rd_addr;
  logic [DATA_W-1:0]   w_rd_data;
  logic [DATA_W-1:0]   w_ro_mask;
  logic [DATA_W-1:0]   w_wr_mask;
  logic                w_wr_in_range;

  assign w_req = i_cfg_mgmt_rd_en | i_cfg_mgmt_wr_en;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, latency counter and control strobes
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_accept     = 1'b0;
    w_enter_done = 1'b0;
    w_enter_rd   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_accept  = 1'b1;
          w_cnt_nxt = CNT_W'(LATENCY - 1);
          if (LATENCY > 1) begin
            w_state_nxt = S_BUSY;
          end else begin
            w_state_nxt  = S_DONE;
            w_enter_done = 1'b1;
            w_enter_rd   = i_cfg_mgmt_rd_en;
          end
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) begin
          w_state_nxt  = S_DONE;
          w_enter_done = 1'b1;
          w_enter_rd   = ~r_op_wr;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (!w_req) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Read mux: live address only when LATENCY=1 completes straight from IDLE
  always_comb begin
    w_rd_addr = (r_state == S_IDLE) ? i_cfg_mgmt_dwaddr : r_addr;
    w_rd_data = '0;
    if (32'(w_rd_addr) < DEPTH) begin
      case (w_rd_addr)
        DWA_W'(0): w_rd_data = ID_WORD;
        DWA_W'(1): w_rd_data = {16'h0010, r_mem[1][15:0]};
        DWA_W'(2): w_rd_data = CLASSREV_WORD;
        default:   w_rd_data = r_mem[w_rd_addr[ADDR_W-1:0]];
      endcase
    end
  end

  // Write lane mask with read-only bits removed
  always_comb begin
    case (r_addr)
      DWA_W'(0): w_ro_mask = '1;
      DWA_W'(1): w_ro_mask = 32'hFFFF_0000;
      DWA_W'(2): w_ro_mask = '1;
      default:   w_ro_mask = '0;
    endcase
    w_wr_mask     = {{8{r_be[3]}}, {8{r_be[2]}}, {8{r_be[1]}}, {8{r_be[0]}}} & ~w_ro_mask;
    w_wr_in_range = (32'(r_addr) < DEPTH);
  end

  // Request latch, latency counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_be        <= '0;
      r_di        <= '0;
      r_op_wr     <= 1'b0;
      r_cnt       <= '0;
      r_do        <= '0;
      r_done      <= 1'b0;
      r_err_proto <= 1'b0;
      r_rd_count  <= '0;
      r_wr_count  <= '0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_done      <= w_enter_done;
      r_err_proto <= w_accept & i_cfg_mgmt_rd_en & i_cfg_mgmt_wr_en;
      if (w_accept) begin
        r_addr  <= i_cfg_mgmt_dwaddr;
        r_be    <= i_cfg_mgmt_byte_en;
        r_di    <= i_cfg_mgmt_di;
        r_op_wr <= i_cfg_mgmt_wr_en & ~i_cfg_mgmt_rd_en;
      end
      if (w_enter_rd) begin
        r_do <= w_rd_data;
      end
      if (r_state == S_DONE) begin
        if (r_op_wr) begin
          r_wr_count <= r_wr_count + CTR_W'(1);
        end else begin
          r_rd_count <= r_rd_count + CTR_W'(1);
        end
      end
    end
  end

  // Shadow storage, committed at the end of the write's done cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if ((r_state == S_DONE) && r_op_wr && w_wr_in_range) begin
      r_mem[r_addr[ADDR_W-1:0]] <= (r_mem[r_addr[ADDR_W-1:0]] & ~w_wr_mask) | (r_di & w_wr_mask);
    end
  end

  assign o_cfg_mgmt_do         = r_do;
  assign o_cfg_mgmt_rd_wr_done = r_done;
  assign o_err_proto           = r_err_proto;
  assign o_rd_count            = r_rd_count;
  assign o_wr_count            = r_wr_count;

endmodule
